// File: rtl/i2c_imu_target.sv
// ---------------------------------------------------------------------------
// i2c_imu_target
//   I2C target modelling the IMU end of the bus. Answers DEV_ADDR, keeps a
//   register pointer and an NREGS-deep byte register file, and serves
//   register writes plus random/burst reads. The pointer auto-increments
//   and wraps modulo NREGS. A local update port loads sensor values that the
//   bus master reads back.
//
// Ports
//   i_clk        system clock (SCL/SDA are oversampled, f_clk >= 16 x f_SCL)
//   i_rst        synchronous active-high reset
//   i_scl_in     SCL pin level (asynchronous)
//   i_sda_in     SDA pin level (asynchronous)
//   o_sda_oe     1 = pull SDA low (open drain), 0 = release
//   i_upd_valid  local register write strobe
//   i_upd_addr   local write index
//   i_upd_data   local write data
//   o_wr_strobe  one-cycle pulse when the master has written a register
//   o_wr_addr    index of that write
//   o_wr_data    data of that write
//   o_busy       high from an addressed START until STOP or reset
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in the address byte
// ADDR_ACK  | driving ACK for our address, then branch on R/W
// REG       | shifting in the register pointer byte
// REG_ACK   | driving ACK for the pointer byte
// WDATA     | shifting in a data byte, committed on the 8th SCL rise
// WDATA_ACK | driving ACK for a data byte
// RDATA     | shifting a data byte out on SCL falls
// RD_ACK    | sampling the master's ACK/NACK
// IGNORE    | not addressed or read finished; wait for START/STOP
// ---------------------------------------------------------------------------
module i2c_imu_target #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter int         NREGS    = 16,
  localparam int        AW       = $clog2(NREGS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_scl_in,
  input  logic          i_sda_in,
  output logic          o_sda_oe,
  input  logic          i_upd_valid,
  input  logic [AW-1:0] i_upd_addr,
  input  logic [7:0]    i_upd_data,
  output logic          o_wr_strobe,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_wr_data,
  output logic          o_busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  // Two synchroniser flops per pin plus one history flop for edge detection.
  logic r_scl_s1, r_scl_s2, r_scl_h;
  logic r_sda_s1, r_sda_s2, r_sda_h;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_h  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_h  <= 1'b1;
    end else begin
      r_scl_s1 <= i_scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_h  <= r_scl_s2;
      r_sda_s1 <= i_sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_h  <= r_sda_s2;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;

  state_t        r_state;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shreg;
  logic [AW-1:0] r_ptr;
  logic          r_rw;
  logic          r_ack_on;   // ACK already asserted; the next SCL fall ends the ACK clock
  logic          r_sda_oe;
  logic          r_busy;
  logic          r_wr_strobe;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic [7:0]    r_regs [NREGS];

  // Byte as it stands once the bit being sampled on this rise is shifted in.
  logic [7:0] w_byte;
  assign w_byte = {r_shreg[6:0], r_sda_s2};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_ack_on    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      // Local update first so a bus write to the same index in this cycle overrides it.
      if (i_upd_valid) r_regs[i_upd_addr] <= i_upd_data;

      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= '0;
        r_ack_on  <= 1'b0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_ack_on <= 1'b0;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shreg   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                if (w_byte[7:1] == DEV_ADDR) begin
                  r_rw     <= w_byte[0];
                  r_busy   <= 1'b1;
                  r_ack_on <= 1'b0;
                  r_state  <= S_ADDR_ACK;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end

          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_sda_oe <= 1'b1;
                r_ack_on <= 1'b1;
              end else begin
                r_ack_on <= 1'b0;
                if (r_rw) begin
                  // The fall that ends the ACK clock also presents the first data bit.
                  r_sda_oe  <= ~r_regs[r_ptr][7];
                  r_shreg   <= {r_regs[r_ptr][6:0], 1'b0};
                  r_bit_cnt <= 4'd1;
                  r_ptr     <= r_ptr + AW'(1);
                  r_state   <= S_RDATA;
                end else begin
                  r_sda_oe  <= 1'b0;
                  r_bit_cnt <= '0;
                  r_state   <= S_REG;
                end
              end
            end
          end

          S_REG: begin
            if (w_scl_rise) begin
              r_shreg   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                r_ptr     <= w_byte[AW-1:0];
                r_ack_on  <= 1'b0;
                r_state   <= S_REG_ACK;
              end
            end
          end

          S_REG_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_sda_oe <= 1'b1;
                r_ack_on <= 1'b1;
              end else begin
                r_sda_oe  <= 1'b0;
                r_ack_on  <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= S_WDATA;
              end
            end
          end

          S_WDATA: begin
            if (w_scl_rise) begin
              r_shreg   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt     <= '0;
                r_regs[r_ptr] <= w_byte;
                r_wr_strobe   <= 1'b1;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_byte;
                r_ptr         <= r_ptr + AW'(1);
                r_ack_on      <= 1'b0;
                r_state       <= S_WDATA_ACK;
              end
            end
          end

          S_RDATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_RD_ACK;
              end else begin
                r_sda_oe  <= ~r_shreg[7];
                r_shreg   <= {r_shreg[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (!r_sda_s2) begin
                r_shreg   <= r_regs[r_ptr];
                r_ptr     <= r_ptr + AW'(1);
                r_bit_cnt <= '0;
                r_state   <= S_RDATA;
              end else begin
                r_state <= S_IGNORE;
              end
            end
          end

          S_IGNORE: r_sda_oe <= 1'b0;

          default: ;
        endcase
      end
    end
  end

  assign o_sda_oe    = r_sda_oe;
  assign o_busy      = r_busy;
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;

endmodule

// File: tb/tb_i2c_imu_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_imu_target
//   Bit-banged I2C master driving i2c_imu_target. Register contents and the
//   pointer are tracked in a plain array model; write strobes are collected
//   and compared against the expected write list after each transaction.
// ---------------------------------------------------------------------------
module tb_i2c_imu_target;

  localparam int NREGS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       upd_valid;
  logic [3:0] upd_addr;
  logic [7:0] upd_data;
  logic       sda_oe, wr_strobe, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       sda_line;

  always #5 clk = ~clk;

  assign sda_line = m_sda & ~sda_oe;

  i2c_imu_target dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_scl_in    (m_scl),
    .i_sda_in    (sda_line),
    .o_sda_oe    (sda_oe),
    .i_upd_valid (upd_valid),
    .i_upd_addr  (upd_addr),
    .i_upd_data  (upd_data),
    .o_wr_strobe (wr_strobe),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  m_regs [NREGS];
  int          m_ptr;
  logic [11:0] strb_q [$];
  logic [11:0] exp_q  [$];
  logic        oe_seen;

  always @(negedge clk) if (!rst && wr_strobe) strb_q.push_back({wr_addr, wr_data});
  always @(negedge clk) if (sda_oe) oe_seen = 1'b1;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic chk_strobes(input string name);
    chk({name, " strobe count"}, 32'(strb_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < strb_q.size(); i++)
      chk({name, " strobe"}, 32'(strb_q[i]), 32'(exp_q[i]));
    strb_q.delete();
    exp_q.delete();
  endtask

  task automatic wq();
    repeat (5) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
    wq();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;    wq();
    m_scl = 1'b1; wq();
    s = sda_line; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  // Data byte whose commit edge coincides with a local update pulse.
  // The bus commit lands on the 3rd clk edge after the SCL pin rise.
  task automatic write_byte_upd(input logic [7:0] b, input logic [3:0] uidx,
                                input logic [7:0] udat, output logic ack);
    logic s;
    for (int i = 7; i >= 1; i--) clk_bit(b[i], s);
    m_sda = b[0]; wq();
    m_scl = 1'b1;
    repeat (2) @(negedge clk);
    upd_addr = uidx; upd_data = udat; upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    chk("collision strobe aligned", 32'(wr_strobe), 32'(1));
    repeat (2) @(negedge clk);
    m_scl = 1'b0; wq();
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic do_upd(input logic [3:0] idx, input logic [7:0] dat);
    upd_addr = idx; upd_data = dat; upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    m_regs[idx] = dat;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [6:0] dev, input logic [7:0] pbyte, input int n,
                          input string name);
    logic ack, exp_ack;
    logic [7:0] d;
    int p;
    exp_ack = (dev == 7'h68);
    bus_start();
    write_byte({dev, 1'b0}, ack);
    chk({name, " addr ack"}, 32'(ack), 32'(exp_ack));
    if (exp_ack) begin
      write_byte(pbyte, ack);
      chk({name, " ptr ack"}, 32'(ack), 32'(1));
      p = int'(pbyte) % NREGS;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        write_byte(d, ack);
        chk({name, " data ack"}, 32'(ack), 32'(1));
        m_regs[p] = d;
        exp_q.push_back({4'(p), d});
        p = (p + 1) % NREGS;
      end
      m_ptr = p;
      chk({name, " busy before stop"}, 32'(busy), 32'(1));
    end else begin
      chk({name, " busy unaddressed"}, 32'(busy), 32'(0));
      write_byte(8'($urandom), ack);
      chk({name, " ignored data ack"}, 32'(ack), 32'(0));
    end
    bus_stop();
    chk({name, " busy after stop"}, 32'(busy), 32'(0));
    chk_strobes(name);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] pbyte, input int n,
                         input string name);
    logic ack;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      write_byte(8'hD0, ack);
      chk({name, " addr-w ack"}, 32'(ack), 32'(1));
      write_byte(pbyte, ack);
      chk({name, " ptr ack"}, 32'(ack), 32'(1));
      m_ptr = int'(pbyte) % NREGS;
      bus_start();
    end
    write_byte(8'hD1, ack);
    chk({name, " addr-r ack"}, 32'(ack), 32'(1));
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, d);
      chk({name, " data"}, 32'(d), 32'(m_regs[m_ptr]));
      m_ptr = (m_ptr + 1) % NREGS;
    end
    chk({name, " sda released"}, 32'(sda_oe), 32'(0));
    bus_stop();
    chk({name, " busy after stop"}, 32'(busy), 32'(0));
  endtask

  typedef struct {
    logic [6:0] dev;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
    logic [7:0] exp_rb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic ack, s;
    logic [7:0] d;
    logic [6:0] dev;
    int kind;

    vecs[0] = '{7'h68, 8'h03, 8'h5A, 1'b1, 8'h5A};
    vecs[1] = '{7'h50, 8'h03, 8'hFF, 1'b0, 8'h5A};
    vecs[2] = '{7'h68, 8'h13, 8'h99, 1'b1, 8'h99};
    vecs[3] = '{7'h00, 8'h07, 8'h44, 1'b0, 8'h00};
    vecs[4] = '{7'h69, 8'h07, 8'h44, 1'b0, 8'h00};
    vecs[5] = '{7'h68, 8'hFF, 8'hC3, 1'b1, 8'hC3};

    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    oe_seen = 1'b0;
    m_scl = 1'b1; m_sda = 1'b1;
    upd_valid = 1'b0; upd_addr = '0; upd_data = '0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset sda_oe", 32'(sda_oe), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset wr_strobe", 32'(wr_strobe), 32'(0));
    chk("reset wr_addr", 32'(wr_addr), 32'(0));
    chk("reset wr_data", 32'(wr_data), 32'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table: single-byte write then read back through a random read.
    for (int v = 0; v < 6; v++) begin
      bus_start();
      write_byte({vecs[v].dev, 1'b0}, ack);
      chk("vec addr ack", 32'(ack), 32'(vecs[v].exp_ack));
      if (vecs[v].exp_ack) begin
        write_byte(vecs[v].ptr, ack);
        write_byte(vecs[v].data, ack);
        exp_q.push_back({vecs[v].ptr[3:0], vecs[v].data});
        m_regs[vecs[v].ptr[3:0]] = vecs[v].data;
      end
      bus_stop();
      chk_strobes("vec");
      bus_start();
      write_byte(8'hD0, ack);
      write_byte(vecs[v].ptr, ack);
      bus_start();
      write_byte(8'hD1, ack);
      read_byte(1'b1, d);
      bus_stop();
      chk("vec readback", 32'(d), 32'(vecs[v].exp_rb));
      m_ptr = (int'(vecs[v].ptr[3:0]) + 1) % NREGS;
    end

    // Burst write D0,05,A5,3C.
    bus_start();
    write_byte(8'hD0, ack); chk("wr addr ack", 32'(ack), 32'(1));
    chk("wr busy after addr", 32'(busy), 32'(1));
    write_byte(8'h05, ack); chk("wr ptr ack", 32'(ack), 32'(1));
    write_byte(8'hA5, ack); chk("wr data0 ack", 32'(ack), 32'(1));
    write_byte(8'h3C, ack); chk("wr data1 ack", 32'(ack), 32'(1));
    chk("wr busy before stop", 32'(busy), 32'(1));
    bus_stop();
    chk("wr busy after stop", 32'(busy), 32'(0));
    exp_q.push_back({4'h5, 8'hA5});
    exp_q.push_back({4'h6, 8'h3C});
    m_regs[5] = 8'hA5; m_regs[6] = 8'h3C;
    chk_strobes("burst write");
    do_read(1'b1, 8'h05, 2, "burst write rb");

    // Random read of locally loaded sensor values.
    do_upd(4'h4, 8'h12);
    do_upd(4'h5, 8'h34);
    do_read(1'b1, 8'h04, 2, "random read");

    // Address mismatch: SDA never pulled.
    oe_seen = 1'b0;
    do_write(7'h50, 8'h05, 1, "mismatch");
    chk("mismatch no sda pull", 32'(oe_seen), 32'(0));

    // Pointer wrap during a burst write.
    bus_start();
    write_byte(8'hD0, ack);
    write_byte(8'h0F, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack); chk("wrap data1 ack", 32'(ack), 32'(1));
    bus_stop();
    exp_q.push_back({4'hF, 8'h11});
    exp_q.push_back({4'h0, 8'h22});
    m_regs[15] = 8'h11; m_regs[0] = 8'h22;
    chk_strobes("wrap");
    do_read(1'b1, 8'h0F, 2, "wrap rb");

    // Collision on the same index (bus wins) and on different indices (both land).
    bus_start();
    write_byte(8'hD0, ack);
    write_byte(8'h05, ack);
    write_byte_upd(8'h77, 4'h5, 8'hEE, ack); chk("collide same ack", 32'(ack), 32'(1));
    write_byte_upd(8'h88, 4'h9, 8'h5C, ack); chk("collide diff ack", 32'(ack), 32'(1));
    bus_stop();
    exp_q.push_back({4'h5, 8'h77});
    exp_q.push_back({4'h6, 8'h88});
    m_regs[5] = 8'h77; m_regs[6] = 8'h88; m_regs[9] = 8'h5C;
    chk_strobes("collision");
    do_read(1'b1, 8'h05, 2, "collision rb");
    do_read(1'b1, 8'h09, 1, "collision upd rb");

    // STOP in the middle of a data byte: nothing committed.
    bus_start();
    write_byte(8'hD0, ack);
    write_byte(8'h05, ack);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
    bus_stop();
    chk("partial busy", 32'(busy), 32'(0));
    chk_strobes("partial");
    do_read(1'b1, 8'h05, 1, "partial rb");

    // Reset in the middle of a read while SDA is being pulled low.
    do_upd(4'h0, 8'h0F);
    bus_start();
    write_byte(8'hD0, ack);
    write_byte(8'h00, ack);
    bus_start();
    write_byte(8'hD1, ack);
    clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    chk("pre-reset driving zero bit", 32'(sda_oe), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("reset releases sda", 32'(sda_oe), 32'(0));
    m_scl = 1'b1; m_sda = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid-read reset busy", 32'(busy), 32'(0));
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    strb_q.delete();
    exp_q.delete();
    repeat (5) @(negedge clk);
    do_read(1'b0, 8'h00, NREGS, "post-reset regs");

    // Randomised transactions against the array model.
    for (int t = 0; t < 20; t++) begin
      kind = int'($urandom_range(4, 0));
      case (kind)
        0, 1: do_write(7'h68, 8'($urandom), int'($urandom_range(3, 1)), "rnd write");
        2:    do_read(1'b1, 8'($urandom), int'($urandom_range(3, 1)), "rnd read");
        3:    do_read(1'b0, 8'h00, int'($urandom_range(3, 1)), "rnd cur read");
        default: begin
          do_upd(4'($urandom), 8'($urandom));
          dev = 7'($urandom);
          if (dev == 7'h68) dev = 7'h69;
          do_write(dev, 8'($urandom), 1, "rnd foreign");
        end
      endcase
    end
    do_read(1'b1, 8'h00, NREGS, "final regs");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
